uart_rx_fsm_ctrl: RTL and testbench

//  Sequencing controller for the UART receiver. Detects the start-bit falling edge on rx_in and runs the

---
 rtl/uart_rx_fsm_ctrl_if.sv | 29 ++
 rtl/uart_rx_fsm_ctrl.sv | 112 +++++++++++
 tb/tb_uart_rx_fsm_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_ctrl_if.sv
// Bundle between the UART RX sequencing controller and the RX datapath blocks.
// The master side is the controller; the slave side is the serial line plus the checkers.
interface uart_rx_fsm_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             rx_in;
  logic [CNT_W-1:0] prescale;
  logic             par_en;
  logic             strt_glitch;
  logic             par_err;
  logic             stp_err;
  logic [CNT_W-1:0] edge_cnt;
  logic             dat_samp_en;
  logic             strt_chk_en;
  logic             deser_en;
  logic             par_chk_en;
  logic             stp_chk_en;
  logic             data_valid;

  modport master (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid
  );

  modport slave (
    output rx_in, prescale, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid
  );
endinterface

// File: rtl/uart_rx_fsm_ctrl.sv
// UART RX sequencing controller: start detection, oversample/bit counters and
// one-cycle enables for the sampler, deserializer and start/parity/stop checkers.
module uart_rx_fsm_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 6
) (
  input logic                clk,
  input logic                rst,
  uart_rx_fsm_ctrl_if.master bus
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 3);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ERR_CHK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] s_edge;
  logic [CNT_W-1:0] last_edge;
  logic [BIT_W-1:0] bit_cnt;
  logic             par_en_q;
  logic             edge_last;
  logic             edge_s;

  // Strobe at P/2+2 so the sampler's majority vote over P/2-1..P/2+1 has settled.
  always_comb begin
    s_edge    = (p_q >> 1) + CNT_W'(2);
    last_edge = p_q - CNT_W'(1);
    edge_last = (edge_cnt == last_edge);
    edge_s    = (edge_cnt == s_edge);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      p_q      <= '0;
      par_en_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == START) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        p_q      <= bus.prescale;
        par_en_q <= bus.par_en;
      end else if (state_nxt == IDLE || state_nxt == ERR_CHK) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (edge_last) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.rx_in) state_nxt = START;
      START:   if (edge_last) state_nxt = bus.strt_glitch ? IDLE : DATA;
      DATA:    if (edge_last && bit_cnt == BIT_W'(DATA_WIDTH))
                 state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (edge_last) state_nxt = STOP;
      // Leave the stop bit early so a back-to-back start edge is not missed.
      STOP:    if (edge_cnt == s_edge + CNT_W'(1)) state_nxt = ERR_CHK;
      ERR_CHK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.edge_cnt    = edge_cnt;
    bus.dat_samp_en = 1'b0;
    bus.strt_chk_en = 1'b0;
    bus.deser_en    = 1'b0;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.data_valid  = 1'b0;
    case (state)
      START: begin
        bus.dat_samp_en = 1'b1;
        bus.strt_chk_en = edge_s;
      end
      DATA: begin
        bus.dat_samp_en = 1'b1;
        bus.deser_en    = edge_s;
      end
      PARITY: begin
        bus.dat_samp_en = 1'b1;
        bus.par_chk_en  = edge_s;
      end
      STOP: begin
        bus.dat_samp_en = 1'b1;
        bus.stp_chk_en  = edge_s;
      end
      ERR_CHK: bus.data_valid = !bus.stp_err && !(par_en_q && bus.par_err);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// Directed bench for uart_rx_fsm_ctrl: drives serial frames and checker results,
// counts strobes per frame and compares against hand-computed cycle positions.
module tb_uart_rx_fsm_ctrl;

  localparam int unsigned CNT_W = 6;
  localparam int unsigned NONE  = 32'hFFFF_FFFF;

  logic clk;
  logic rst;

  uart_rx_fsm_ctrl_if #(.CNT_W(CNT_W)) bus ();

  uart_rx_fsm_ctrl #(.DATA_WIDTH(8), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks;
  int errors;

  int unsigned n_strt, n_deser, n_par, n_stp, n_valid;
  int unsigned valid_cyc, end_cyc, par_cyc, stp_cyc, bad_edge, overlap;
  logic [7:0]  rx_byte;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
            bus.par_chk_en, bus.stp_chk_en, bus.data_valid};
  endfunction

  // Cycle 0 is the first START cycle; the frame ends on the first later cycle
  // with dat_samp_en low (ERR_CHK, or IDLE after a false start).
  task automatic run_frame(input int unsigned p, input logic par, input logic [7:0] d,
                           input logic glitch, input logic perr, input logic serr,
                           input int unsigned start_low, input int unsigned stop_at,
                           input logic mid_change);
    int unsigned limit, s, b, nstr;
    limit = 12 * p + 10;
    s = p / 2 + 2;
    n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_valid = 0;
    valid_cyc = NONE; end_cyc = NONE; par_cyc = NONE; stp_cyc = NONE;
    bad_edge = 0; overlap = 0; rx_byte = '0;
    @(negedge clk);
    bus.prescale    = CNT_W'(p);
    bus.par_en      = par;
    bus.strt_glitch = glitch;
    bus.par_err     = perr;
    bus.stp_err     = serr;
    bus.rx_in       = 1'b0;
    for (int unsigned t = 0; t <= limit; t++) begin
      @(negedge clk);
      nstr = 32'(bus.strt_chk_en) + 32'(bus.deser_en) + 32'(bus.par_chk_en) + 32'(bus.stp_chk_en);
      if (nstr > 1) overlap++;
      if (nstr != 0 && bus.edge_cnt != CNT_W'(s)) bad_edge++;
      if (bus.strt_chk_en) n_strt++;
      if (bus.deser_en) begin
        n_deser++;
        rx_byte = {bus.rx_in, rx_byte[7:1]};
      end
      if (bus.par_chk_en) begin n_par++; par_cyc = t; end
      if (bus.stp_chk_en) begin n_stp++; stp_cyc = t; end
      if (bus.data_valid) begin n_valid++; valid_cyc = t; end
      if (t > 0 && !bus.dat_samp_en) begin
        end_cyc = t;
        break;
      end
      if (t == stop_at) break;
      b = (t + 1) / p;
      if (b == 0)                bus.rx_in = ((t + 1) < start_low) ? 1'b0 : 1'b1;
      else if (b <= 8)           bus.rx_in = d[b-1];
      else if (b == 9 && par)    bus.rx_in = ^d;
      else                       bus.rx_in = 1'b1;
      if (mid_change && t == 20) begin
        bus.prescale = CNT_W'(8);
        bus.par_en   = ~par;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rx_in = 1'b1; bus.prescale = CNT_W'(8); bus.par_en = 1'b0;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_edge_cnt", 32'(bus.edge_cnt), 0);
    check("rst_outs", 32'(outs()), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_outs", 32'(outs()), 0);

    // 1: P=8, no parity, 0xA5
    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8, NONE, 1'b0);
    check("t1_end", end_cyc, 80);
    check("t1_valid_cyc", valid_cyc, 80);
    check("t1_n_valid", n_valid, 1);
    check("t1_n_deser", n_deser, 8);
    check("t1_byte", 32'(rx_byte), 32'hA5);
    check("t1_n_strt", n_strt, 1);
    check("t1_n_stp", n_stp, 1);
    check("t1_stp_cyc", stp_cyc, 78);
    check("t1_n_par", n_par, 0);
    check("t1_bad_edge", bad_edge, 0);
    check("t1_overlap", overlap, 0);

    // 2: false start, line low 3 cycles
    run_frame(8, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3, NONE, 1'b0);
    check("t2_end", end_cyc, 8);
    check("t2_n_strt", n_strt, 1);
    check("t2_n_deser", n_deser, 0);
    check("t2_n_valid", n_valid, 0);
    check("t2_n_stp", n_stp, 0);

    // 3: P=16 with parity, parity error
    run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 16, NONE, 1'b0);
    check("t3_n_par", n_par, 1);
    check("t3_par_cyc", par_cyc, 154);
    check("t3_end", end_cyc, 172);
    check("t3_n_valid", n_valid, 0);
    check("t3_n_deser", n_deser, 8);
    check("t3_byte", 32'(rx_byte), 32'h3C);
    check("t3_bad_edge", bad_edge, 0);
    check("t3_overlap", overlap, 0);
    bus.par_err = 1'b0;
    @(negedge clk);
    check("t3_idle_after", 32'(outs()), 0);

    // 4: stop error; then line low during ERR_CHK is ignored for that cycle
    run_frame(8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 8, NONE, 1'b0);
    check("t4_n_stp", n_stp, 1);
    check("t4_end", end_cyc, 80);
    check("t4_n_valid", n_valid, 0);
    bus.rx_in = 1'b0;
    @(negedge clk);
    check("t4_errchk_rx_ignored", 32'(bus.dat_samp_en), 0);
    @(negedge clk);
    check("t4_start_next", 32'(bus.dat_samp_en), 1);
    check("t4_start_edge0", 32'(bus.edge_cnt), 0);
    bus.rx_in = 1'b1;
    bus.strt_glitch = 1'b1;
    bus.stp_err = 1'b0;
    k = NONE;
    for (int unsigned i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!bus.dat_samp_en) begin
        k = i;
        break;
      end
    end
    check("t4_abort_len", k, 8);
    bus.strt_glitch = 1'b0;

    // 5: async reset in DATA bit 4, then a clean frame
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8, 35, 1'b0);
    check("t5_pre_edge", 32'(bus.edge_cnt), 3);
    check("t5_pre_n_deser", n_deser, 3);
    check("t5_pre_samp", 32'(bus.dat_samp_en), 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_edge_cnt", 32'(bus.edge_cnt), 0);
    check("t5_rst_outs", 32'(outs()), 0);
    bus.rx_in = 1'b1;
    #1 rst = 1'b0;
    run_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 8, NONE, 1'b0);
    check("t5_valid_cyc", valid_cyc, 80);
    check("t5_byte", 32'(rx_byte), 32'h96);

    // 6: P=32 back-to-back, prescale/par_en disturbed mid-frame
    run_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 32, NONE, 1'b1);
    check("t6a_valid_cyc", valid_cyc, 308);
    check("t6a_n_valid", n_valid, 1);
    check("t6a_byte", 32'(rx_byte), 32'hC3);
    check("t6a_n_par", n_par, 0);
    check("t6a_bad_edge", bad_edge, 0);
    run_frame(32, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 32, NONE, 1'b0);
    check("t6b_valid_cyc", valid_cyc, 308);
    check("t6b_n_valid", n_valid, 1);
    check("t6b_byte", 32'(rx_byte), 32'h7E);
    check("t6b_n_deser", n_deser, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
